eeg_omux_quant: RTL and testbench
=================================

// Module: eeg_omux_quant
// PURPOSE
//  Output-mux collector between one PE (OUT_VLD/OUT_RDY/OUT_ADD/psum) and the ORAM write path.
//  Captures 24-bit signed partial sums into a DEPTH-entry register buffer, overwriting or
//  accumulating at the supplied address, and on the last psum of a tile drains the buffer
//  in address order. Drained values are requantised to OUT_DW bits (round, shift, ReLU, saturate).
// PARAMETERS
//  PSUM_DW   24  psum width, signed
//  OUT_DW    8   quantised output width, signed
//  DEPTH     16  buffer entries (OMUX_RAM_DW); power of two
//  ADD_AW    4   address width, log2(DEPTH)
//  SHIFT_DW  5   requantisation shift field width
// PORTS
//  clk        in   1         clock
//  rst_n      in   1         async active-low reset
//  cfg_start  in   1         tile start pulse; honoured only in IDLE
//  cfg_shift  in   SHIFT_DW  right-shift amount, sampled on accepted cfg_start
//  cfg_relu   in   1         clamp negatives to 0, sampled on accepted cfg_start
//  in_vld     in   1         psum valid
//  in_rdy     out  1         psum ready
//  in_add     in   ADD_AW    psum buffer address
//  in_dat     in   PSUM_DW   psum value, signed
//  in_acc     in   1         1: buf[add]+=dat, 0: buf[add]=dat
//  in_lst     in   1         last psum of tile
//  out_vld    out  1         quantised data valid
//  out_rdy    in   1         downstream ready
//  out_add    out  ADD_AW    buffer index of out_dat
//  out_dat    out  OUT_DW    quantised value, signed
//  out_lst    out  1         marks index DEPTH-1
//  busy       out  1         state != IDLE
//  done       out  1         one-cycle pulse after last drain handshake
// BEHAVIOUR
//  Reset: state=IDLE; in_rdy, out_vld, out_lst, busy, done=0; out_add, out_dat=0; buffer, cfg regs=0.
//  FSM IDLE -> FILL on cfg_start: same edge clears all buffer entries, latches cfg_shift/cfg_relu.
//   cfg_start in FILL/DRAIN ignored.
//  FILL: in_rdy=1. Write on in_vld&&in_rdy, visible next cycle. Back-to-back acc to same add
//   must chain (cycle n+1 uses cycle n result). Accumulation saturates to signed PSUM_DW
//   range [-2^23, 2^23-1], never wraps. Accepted in_lst -> DRAIN; that psum is still written.
//  DRAIN: in_rdy=0. Index counter starts 0; out_vld rises the cycle after entering DRAIN.
//   out_vld/out_add/out_dat/out_lst held stable while out_vld && !out_rdy.
//   On handshake index increments, next entry presented the following cycle (1 word/cycle when
//   out_rdy held high). Handshake with out_lst=1 -> out_vld=0, done=1 for one cycle, -> IDLE.
//  Quant (on buffer read, registered into out_dat): r = shift==0 ? v : (v + 2^(shift-1)) >>> shift,
//   computed in PSUM_DW+1 bits so rounding cannot overflow; if cfg_relu and r<0, r=0; then
//   saturate to [-2^(OUT_DW-1), 2^(OUT_DW-1)-1]. shift >= PSUM_DW yields 0 or -1 per sign.
//  Buffer is not cleared by drain; contents persist until next accepted cfg_start.
//  rst_n asserted mid-FILL/DRAIN: immediate return to reset values; no partial output.
// TESTING
//  1 cfg_start shift=0 relu=0; write add0=5, add1=-3 (acc=0), lst on add15=127 -> drain
//    0:5, 1:-3, 2..14:0, 15:127 with out_lst only at 15, done one cycle after.
//  2 shift=4 relu=0; add3: 100 then acc +60 back-to-back (=160) -> out[3]=10; add4=24 -> 2
//    (round half up 1.5->2); add5=-24 -> -1.
//  3 Saturation: shift=0, add0=300 -> 127, add1=-300 -> -128; acc 2^23-1 + 10 at add2
//    with shift=16 -> 128 pre-sat -> 127; relu=1 with add3=-50 -> 0.
//  4 out_rdy random 50% during drain -> outputs stable while stalled, 16 words in order,
//    no drops/duplicates; cfg_start pulsed during DRAIN ignored (cfg unchanged, no restart).
//  5 rst_n low mid-DRAIN at index 7 -> out_vld=0, busy=0 next; new tile -> all entries
//    start from 0 (no residue from prior tile).
//  6 Two consecutive tiles: second tile writes add0 only with lst -> drain shows add0 value
//    and zeros elsewhere (cleared at cfg_start).

Source files
------------

// File: rtl/eeg_omux_quant_if.sv
// -----------------------------------------------------------------------------
// eeg_omux_quant_if
// Purpose : bundles the two streaming handshakes of the output-mux collector.
//           The psum side (in_*) comes from one PE; the quantised side (out_*)
//           feeds the ORAM write path.
// Handshake: a word moves on a rising clk edge where vld && rdy are both high.
//           The sender holds vld and its payload stable until that edge; the
//           receiver may drive rdy freely and it is sampled on the same edge.
// Signals :
//   in_vld/in_rdy   psum handshake
//   in_add          buffer address of the psum
//   in_dat          signed psum value
//   in_acc          1 = accumulate into the entry, 0 = overwrite it
//   in_lst          last psum of the tile
//   out_vld/out_rdy quantised-data handshake
//   out_add         buffer index of out_dat
//   out_dat         signed quantised value
//   out_lst         marks the final buffer index
// Modports: slave  = the collector (eeg_omux_quant)
//           master = the environment driving psums and sinking outputs
// -----------------------------------------------------------------------------
interface eeg_omux_quant_if #(
  parameter int PSUM_DW = 24,
  parameter int OUT_DW  = 8,
  parameter int ADD_AW  = 4
);
  logic                      in_vld;
  logic                      in_rdy;
  logic [ADD_AW-1:0]         in_add;
  logic signed [PSUM_DW-1:0] in_dat;
  logic                      in_acc;
  logic                      in_lst;
  logic                      out_vld;
  logic                      out_rdy;
  logic [ADD_AW-1:0]         out_add;
  logic signed [OUT_DW-1:0]  out_dat;
  logic                      out_lst;

  modport slave (
    input  in_vld, in_add, in_dat, in_acc, in_lst, out_rdy,
    output in_rdy, out_vld, out_add, out_dat, out_lst
  );

  modport master (
    output in_vld, in_add, in_dat, in_acc, in_lst, out_rdy,
    input  in_rdy, out_vld, out_add, out_dat, out_lst
  );
endinterface

// File: rtl/eeg_omux_quant.sv
// -----------------------------------------------------------------------------
// eeg_omux_quant
// Purpose : output-mux collector between one PE and the ORAM write path.
//           Psums are captured into a DEPTH-entry register buffer (overwrite or
//           saturating accumulate). The last psum of a tile switches to a drain
//           that walks the buffer in address order, requantising each entry to
//           OUT_DW bits (round half up, arithmetic shift, optional ReLU,
//           saturate).
// Ports   :
//   clk, rst_n     clock, asynchronous active-low reset
//   cfg_start      tile start pulse, honoured only in IDLE
//   cfg_shift      requantisation right shift, latched on accepted cfg_start
//   cfg_relu       clamp negatives to 0, latched on accepted cfg_start
//   bus            psum and output streams (eeg_omux_quant_if.slave)
//   busy           high whenever the FSM is not IDLE
//   done           one-cycle pulse after the last drain handshake
//   dbg_state      current FSM state (0 IDLE, 1 FILL, 2 DRAIN)
// -----------------------------------------------------------------------------
module eeg_omux_quant #(
  parameter int PSUM_DW  = 24,
  parameter int OUT_DW   = 8,
  parameter int DEPTH    = 16,
  parameter int ADD_AW   = 4,
  parameter int SHIFT_DW = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_start,
  input  logic [SHIFT_DW-1:0] cfg_shift,
  input  logic                cfg_relu,
  eeg_omux_quant_if.slave     bus,
  output logic                busy,
  output logic                done,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // Quantiser clamp limits, expressed in the widened PSUM_DW+1 domain.
  localparam logic signed [PSUM_DW:0] QMAX =
    {{(PSUM_DW+2-OUT_DW){1'b0}}, {(OUT_DW-1){1'b1}}};
  localparam logic signed [PSUM_DW:0] QMIN =
    {{(PSUM_DW+2-OUT_DW){1'b1}}, {(OUT_DW-1){1'b0}}};
  localparam logic signed [PSUM_DW:0] ONE = {{PSUM_DW{1'b0}}, 1'b1};
  localparam logic [ADD_AW-1:0]       LAST_IDX = ADD_AW'(DEPTH-1);

  state_t                    r_state;
  logic signed [PSUM_DW-1:0] r_buf [DEPTH];
  logic [SHIFT_DW-1:0]       r_shift;
  logic                      r_relu;
  logic                      r_out_vld;
  logic [ADD_AW-1:0]         r_out_add;
  logic signed [OUT_DW-1:0]  r_out_dat;
  logic                      r_out_lst;
  logic                      r_done;

  logic signed [PSUM_DW-1:0] w_old;
  logic signed [PSUM_DW:0]   w_sum;
  logic signed [PSUM_DW-1:0] w_wr_val;
  logic [ADD_AW-1:0]         w_rd_idx;
  logic signed [OUT_DW-1:0]  w_q;

  // Requantise one buffer entry. The rounding add is done one bit wider than
  // the psum so v + 2^(shift-1) can never overflow. Shifts at or beyond the
  // psum width collapse to the sign (0 or -1).
  function automatic logic signed [OUT_DW-1:0] quant(
    input logic signed [PSUM_DW-1:0] v,
    input logic [SHIFT_DW-1:0]       sh,
    input logic                      relu
  );
    logic signed [PSUM_DW:0] w;
    logic signed [PSUM_DW:0] rnd;
    logic signed [PSUM_DW:0] r;
    w   = {v[PSUM_DW-1], v};
    rnd = '0;
    if (sh == '0) begin
      r = w;
    end else if (int'(sh) >= PSUM_DW) begin
      r = v[PSUM_DW-1] ? '1 : '0;
    end else begin
      rnd = ONE <<< (sh - SHIFT_DW'(1));
      r   = (w + rnd) >>> sh;
    end
    if (relu && r[PSUM_DW]) begin
      r = '0;
    end
    if (r > QMAX) begin
      r = QMAX;
    end else if (r < QMIN) begin
      r = QMIN;
    end
    return r[OUT_DW-1:0];
  endfunction

  // Write path: the entry read here already holds the previous cycle's write,
  // so back-to-back accumulates to one address chain naturally. The sum is
  // formed one bit wider; a top-two-bit disagreement means overflow.
  always_comb begin
    w_old = r_buf[bus.in_add];
    w_sum = {w_old[PSUM_DW-1], w_old} + {bus.in_dat[PSUM_DW-1], bus.in_dat};
    w_wr_val = bus.in_dat;
    if (bus.in_acc) begin
      if (w_sum[PSUM_DW] != w_sum[PSUM_DW-1]) begin
        w_wr_val = w_sum[PSUM_DW] ? {1'b1, {(PSUM_DW-1){1'b0}}}
                                  : {1'b0, {(PSUM_DW-1){1'b1}}};
      end else begin
        w_wr_val = w_sum[PSUM_DW-1:0];
      end
    end
  end

  // Drain read index: entry 0 when nothing is presented yet, otherwise the
  // entry after the one currently on the output.
  always_comb begin
    w_rd_idx = r_out_vld ? (r_out_add + ADD_AW'(1)) : '0;
    w_q      = quant(r_buf[w_rd_idx], r_shift, r_relu);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_relu    <= 1'b0;
      r_out_vld <= 1'b0;
      r_out_add <= '0;
      r_out_dat <= '0;
      r_out_lst <= 1'b0;
      r_done    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cfg_start) begin
            for (int i = 0; i < DEPTH; i++) begin
              r_buf[i] <= '0;
            end
            r_shift <= cfg_shift;
            r_relu  <= cfg_relu;
            r_state <= S_FILL;
          end
        end
        S_FILL: begin
          if (bus.in_vld) begin
            r_buf[bus.in_add] <= w_wr_val;
            if (bus.in_lst) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (!r_out_vld) begin
            r_out_vld <= 1'b1;
            r_out_add <= w_rd_idx;
            r_out_dat <= w_q;
            r_out_lst <= (w_rd_idx == LAST_IDX);
          end else if (bus.out_rdy) begin
            if (r_out_lst) begin
              r_out_vld <= 1'b0;
              r_out_lst <= 1'b0;
              r_done    <= 1'b1;
              r_state   <= S_IDLE;
            end else begin
              r_out_add <= w_rd_idx;
              r_out_dat <= w_q;
              r_out_lst <= (w_rd_idx == LAST_IDX);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_rdy  = (r_state == S_FILL);
  assign bus.out_vld = r_out_vld;
  assign bus.out_add = r_out_add;
  assign bus.out_dat = r_out_dat;
  assign bus.out_lst = r_out_lst;
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_eeg_omux_quant.sv
// -----------------------------------------------------------------------------
// tb_eeg_omux_quant
// Drives directed and randomized tiles into eeg_omux_quant and checks every
// drained word against a behavioural model of the buffer and requantiser.
// Inputs are driven and outputs observed on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_eeg_omux_quant;

  localparam int PSUM_DW  = 24;
  localparam int OUT_DW   = 8;
  localparam int DEPTH    = 16;
  localparam int ADD_AW   = 4;
  localparam int SHIFT_DW = 5;
  localparam int EW       = 1 + ADD_AW + OUT_DW;

  // ---------------- clock / reset ----------------
  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                cfg_start = 1'b0;
  logic [SHIFT_DW-1:0] cfg_shift = '0;
  logic                cfg_relu = 1'b0;
  logic                busy;
  logic                done;
  logic [1:0]          dbg_state;

  always #5 clk = ~clk;

  eeg_omux_quant_if #(.PSUM_DW(PSUM_DW), .OUT_DW(OUT_DW), .ADD_AW(ADD_AW)) bus ();

  eeg_omux_quant #(
    .PSUM_DW(PSUM_DW), .OUT_DW(OUT_DW), .DEPTH(DEPTH),
    .ADD_AW(ADD_AW), .SHIFT_DW(SHIFT_DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_start (cfg_start),
    .cfg_shift (cfg_shift),
    .cfg_relu  (cfg_relu),
    .bus       (bus.slave),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // ---------------- reference model ----------------
  longint m_buf [DEPTH];
  int     m_shift;
  bit     m_relu;

  function automatic longint sat_psum(input longint x);
    if (x > 64'sd8388607)  return 64'sd8388607;
    if (x < -64'sd8388608) return -64'sd8388608;
    return x;
  endfunction

  function automatic longint quant_ref(input longint v, input int sh, input bit relu);
    longint r;
    if (sh == 0)        r = v;
    else if (sh >= 24)  r = (v < 0) ? -1 : 0;
    else                r = (v + (longint'(1) <<< (sh - 1))) >>> sh;
    if (relu && r < 0)  r = 0;
    if (r > 127)        r = 127;
    if (r < -128)       r = -128;
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_vld = 1'b0; bus.in_add = '0; bus.in_dat = '0;
    bus.in_acc = 1'b0; bus.in_lst = 1'b0; bus.out_rdy = 1'b0;
    cfg_start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic start_tile(input int sh, input bit relu);
    cfg_shift = SHIFT_DW'(sh);
    cfg_relu  = relu;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    m_shift = sh;
    m_relu  = relu;
    for (int i = 0; i < DEPTH; i++) m_buf[i] = 0;
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_in_rdy", {31'd0, bus.in_rdy}, 32'd1);
  endtask

  task automatic send(input int add, input longint dat, input bit acc, input bit lst);
    logic [63:0] d64;
    d64 = dat;
    bus.in_vld = 1'b1;
    bus.in_add = ADD_AW'(add);
    bus.in_dat = d64[PSUM_DW-1:0];
    bus.in_acc = acc;
    bus.in_lst = lst;
    @(negedge clk);
    bus.in_vld = 1'b0;
    bus.in_lst = 1'b0;
    if (acc) m_buf[add] = sat_psum(m_buf[add] + dat);
    else     m_buf[add] = dat;
  endtask

  function automatic longint rand_psum();
    logic [PSUM_DW-1:0] r24;
    r24 = PSUM_DW'($urandom);
    if ($urandom_range(0, 1) == 0) return longint'($urandom_range(0, 1000)) - 500;
    return longint'($signed(r24));
  endfunction

  task automatic load_expected();
    longint q;
    logic [63:0] q64;
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      q   = quant_ref(m_buf[i], m_shift, m_relu);
      q64 = q;
      exp_q.push_back({(i == DEPTH - 1), ADD_AW'(i), q64[OUT_DW-1:0]});
    end
  endtask

  // Called at the falling edge right after the last psum was accepted.
  task automatic drain(input int rdy_pct, input bit poke_start);
    logic [EW-1:0] held;
    logic [EW-1:0] obs;
    logic [EW-1:0] exp;
    bit stalled;
    bit fin;
    int it;
    stalled = 0; fin = 0; it = 0; held = '0;
    load_expected();
    chk("drain_in_rdy", {31'd0, bus.in_rdy}, 32'd0);
    while (!fin && it < 200) begin
      obs = {bus.out_lst, bus.out_add, bus.out_dat};
      if (it == 0) chk("drain_vld_lat0", {31'd0, bus.out_vld}, 32'd0);
      if (it == 1) chk("drain_vld_lat1", {31'd0, bus.out_vld}, 32'd1);
      if (stalled) begin
        chk("stall_vld", {31'd0, bus.out_vld}, 32'd1);
        chk("stall_hold", 32'(obs), 32'(held));
      end
      if (poke_start) begin
        cfg_start = (it == 3);
        cfg_shift = SHIFT_DW'($urandom_range(0, 31));
        cfg_relu  = ~m_relu;
      end
      bus.out_rdy = ($urandom_range(0, 99) < rdy_pct);
      stalled = 0;
      if (bus.out_vld && bus.out_rdy) begin
        if (exp_q.size() == 0) begin
          chk("drain_extra_word", 32'd1, 32'd0);
        end else begin
          exp = exp_q.pop_front();
          chk("drain_word", 32'(obs), 32'(exp));
        end
        if (bus.out_lst) fin = 1;
      end else if (bus.out_vld) begin
        stalled = 1;
        held = obs;
      end
      @(negedge clk);
      it++;
    end
    bus.out_rdy = 1'b0;
    cfg_start = 1'b0;
    if (!fin) chk("drain_timeout", 32'd0, 32'd1);
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("done_vld_low", {31'd0, bus.out_vld}, 32'd0);
    chk("done_idle", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("done_once", {31'd0, done}, 32'd0);
    chk("no_restart", {31'd0, busy}, 32'd0);
  endtask

  task automatic rand_tile(input bit poke);
    int n;
    start_tile($urandom_range(0, 25), 1'($urandom_range(0, 1)));
    n = $urandom_range(4, 24);
    for (int k = 0; k < n; k++) begin
      send($urandom_range(0, DEPTH - 1), rand_psum(), 1'($urandom_range(0, 1)), 1'b0);
    end
    send($urandom_range(0, DEPTH - 1), rand_psum(), 1'($urandom_range(0, 1)), 1'b1);
    drain(50, poke);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit hit;
    do_reset();

    // reset state
    chk("rst_out_vld", {31'd0, bus.out_vld}, 32'd0);
    chk("rst_in_rdy",  {31'd0, bus.in_rdy},  32'd0);
    chk("rst_busy",    {31'd0, busy},        32'd0);
    chk("rst_done",    {31'd0, done},        32'd0);
    chk("rst_out_lst", {31'd0, bus.out_lst}, 32'd0);
    chk("rst_out_add", 32'(bus.out_add),     32'd0);
    chk("rst_out_dat", 32'(bus.out_dat),     32'd0);

    // overwrite, zeros elsewhere, last index
    start_tile(0, 0);
    send(0, 5, 0, 0);
    send(1, -3, 0, 0);
    send(15, 127, 0, 1);
    drain(100, 0);

    // rounding and back-to-back accumulate chaining
    start_tile(4, 0);
    send(3, 100, 0, 0);
    send(3, 60, 1, 0);
    send(4, 24, 0, 0);
    send(5, -24, 0, 1);
    drain(100, 0);

    // output saturation both ways
    start_tile(0, 0);
    send(0, 300, 0, 0);
    send(1, -300, 0, 1);
    drain(100, 0);

    // psum saturation then large shift
    start_tile(16, 0);
    send(2, 8388607, 0, 0);
    send(2, 10, 1, 1);
    drain(100, 0);

    // negative psum saturation and shift beyond psum width
    start_tile(24, 0);
    send(6, -8388608, 0, 0);
    send(6, -5, 1, 0);
    send(7, 8388607, 0, 0);
    send(8, -1, 0, 1);
    drain(100, 0);

    // ReLU
    start_tile(0, 1);
    send(3, -50, 0, 0);
    send(4, 40, 0, 1);
    drain(100, 0);

    // random back-pressure with ignored cfg_start during drain
    rand_tile(1);
    rand_tile(1);

    // reset in the middle of a drain
    start_tile(0, 0);
    for (int i = 0; i < DEPTH - 1; i++) send(i, i + 1, 0, 0);
    send(DEPTH - 1, 99, 0, 1);
    hit = 0;
    for (int it = 0; it < 60 && !hit; it++) begin
      bus.out_rdy = 1'b1;
      if (bus.out_vld && bus.out_add == ADD_AW'(7)) begin
        rst_n = 1'b0;
        hit = 1;
      end else begin
        @(negedge clk);
      end
    end
    if (!hit) chk("mid_reset_timeout", 32'd0, 32'd1);
    bus.out_rdy = 1'b0;
    @(negedge clk);
    chk("mid_rst_vld",  {31'd0, bus.out_vld}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy},        32'd0);
    chk("mid_rst_dat",  32'(bus.out_dat),     32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    start_tile(2, 0);
    send(9, 17, 1, 1);
    drain(100, 0);

    // two consecutive tiles: second must not see the first one's data
    start_tile(0, 0);
    for (int i = 0; i < DEPTH - 1; i++) send(i, longint'($urandom_range(1, 120)), 0, 0);
    send(DEPTH - 1, 77, 0, 1);
    drain(70, 0);
    start_tile(0, 0);
    send(0, -42, 0, 1);
    drain(100, 0);

    // more random tiles
    for (int t = 0; t < 4; t++) rand_tile(t[0]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
